// File: rtl/switch_box_segment_endpoint.sv
// switch_box_segment_endpoint: one end of a time-division shared routing segment.
// Two endpoints (MASTER=1 / MASTER=0) alternate driving a tri-state bus on a fixed
// frame of 2*(SLOT+GUARD) cycles, with high-Z guard gaps between the two slots.
// Optional feature macro: SWITCH_BOX_PARITY_EN (adds an even-parity bit at bus[W+1]).
module switch_box_segment_endpoint #(
    parameter int W      = 8,
    parameter int SLOT   = 4,
    parameter int GUARD  = 1,
    parameter int MASTER = 1
) (
    input  logic         clk,
    input  logic         rst,
`ifdef SWITCH_BOX_PARITY_EN
    inout  wire  [W+1:0] bus,
`else
    inout  wire  [W:0]   bus,
`endif
    input  logic [W-1:0] tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    output logic [W-1:0] rx_data,
    output logic         rx_valid,
    output logic         rx_err,
    output logic         bus_oe
);

    localparam int FRAME = 2 * (SLOT + GUARD);
    localparam int PW    = $clog2(FRAME);
    localparam int OWN_S = (MASTER != 0) ? 0 : SLOT + GUARD;
`ifdef SWITCH_BOX_PARITY_EN
    localparam int BW    = W + 2;
`else
    localparam int BW    = W + 1;
`endif

    typedef enum logic [1:0] {OWN, GUARD_A, PEER, GUARD_B} state_t;

    // Classify a phase relative to the start of this endpoint's own slot.
    function automatic state_t state_of(input logic [PW-1:0] p);
        int rel;
        rel = (int'(p) + FRAME - OWN_S) % FRAME;
        if (rel < SLOT)                   return OWN;
        else if (rel < SLOT + GUARD)      return GUARD_A;
        else if (rel < 2 * SLOT + GUARD)  return PEER;
        else                              return GUARD_B;
    endfunction

    logic [PW-1:0] ph;
    logic [PW-1:0] ph_next;
    state_t        st;
    state_t        st_now;
    logic          hs;
    logic          sample_now;
    logic [W-1:0]  word;
    logic          vflag;
    logic          oe_q;
    logic [BW-1:0] drv;

    assign ph_next = (ph == PW'(FRAME - 1)) ? '0 : ph + 1'b1;
    assign st_now  = state_of(ph);
    assign hs      = tx_valid && tx_ready;

    // st lags ph by one cycle, so st==OWN / st==PEER coincide exactly with the
    // drive windows (which start the cycle after the handshake edge). The last
    // PEER cycle is therefore the last cycle the peer holds the bus.
    assign sample_now = (st == PEER) && (st_now != PEER);

`ifdef SWITCH_BOX_PARITY_EN
    assign drv = {^{vflag, word}, vflag, word};
`else
    assign drv = {vflag, word};
`endif

    assign bus    = oe_q ? drv : 'z;
    assign bus_oe = oe_q;

    // Phase counter, lagged state, transmit handshake and drive enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph       <= '0;
            st       <= state_of(PW'(FRAME - 1));
            tx_ready <= 1'b0;
            oe_q     <= 1'b0;
            vflag    <= 1'b0;
            word     <= '0;
        end else begin
            ph       <= ph_next;
            st       <= st_now;
            tx_ready <= (ph_next == PW'(OWN_S));
            if (hs) begin
                word  <= tx_data;
                vflag <= 1'b1;
                oe_q  <= 1'b1;
            end else if (st_now != OWN) begin
                oe_q  <= 1'b0;
                vflag <= 1'b0;
            end
        end
    end

    // Capture the peer's word in the last cycle of its slot; strobe it next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid <= 1'b0;
            rx_data  <= '0;
`ifdef SWITCH_BOX_PARITY_EN
            rx_err   <= 1'b0;
`endif
        end else if (sample_now && (bus[W] == 1'b1)) begin
            rx_valid <= 1'b1;
            rx_data  <= bus[W-1:0];
`ifdef SWITCH_BOX_PARITY_EN
            rx_err   <= ^bus;
`endif
        end else begin
            rx_valid <= 1'b0;
`ifdef SWITCH_BOX_PARITY_EN
            rx_err   <= 1'b0;
`endif
        end
    end

`ifndef SWITCH_BOX_PARITY_EN
    assign rx_err = 1'b0;
`endif

endmodule
